chip8_keypad: RTL

CHIP8_KEYPAD -- requirements
Module: chip8_keypad

---
 rtl/chip8_keypad.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/chip8_keypad.sv
// rtl/chip8_keypad.sv - PS/2 scancode to CHIP-8 16-key matrix tracker with FX0A-style key-wait FSM
module chip8_keypad #(
    parameter bit WAIT_ON_RELEASE = 1'b1
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic [10:0] ps2_key,
    input  logic        clear,
    output logic [15:0] key_matrix,
    input  logic        wait_req,
    output logic        wait_done,
    output logic [3:0]  wait_key
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_HELD,
        ST_DONE,
        ST_ACK
    } state_t;

    logic [10:0] ps2_q;
    logic        tog_q;
    logic        tog_d;
    logic        primed_q;
    logic [15:0] km_q;
    logic [15:0] km_d;
    state_t      state_q;
    state_t      state_d;
    logic [3:0]  wait_key_q;
    logic [3:0]  wait_key_d;
    logic        done_q;
    logic        done_d;

    logic        evt;
    logic        map_hit;
    logic [3:0]  map_key;
    logic        key_evt;
    logic        fresh_press;
    logic        key_release;

    // PS/2 set-2 scancodes for the classic 4x4 layout starting at the "1" key
    always_comb begin
        map_hit = 1'b1;
        map_key = 4'h0;
        unique case (ps2_q[7:0])
            8'h16:   map_key = 4'h1;
            8'h1E:   map_key = 4'h2;
            8'h26:   map_key = 4'h3;
            8'h25:   map_key = 4'hC;
            8'h15:   map_key = 4'h4;
            8'h1D:   map_key = 4'h5;
            8'h24:   map_key = 4'h6;
            8'h2D:   map_key = 4'hD;
            8'h1C:   map_key = 4'h7;
            8'h1B:   map_key = 4'h8;
            8'h23:   map_key = 4'h9;
            8'h2B:   map_key = 4'hE;
            8'h1A:   map_key = 4'hA;
            8'h22:   map_key = 4'h0;
            8'h21:   map_key = 4'hB;
            8'h2A:   map_key = 4'hF;
            default: map_hit = 1'b0;
        endcase
    end

    assign evt         = primed_q && (ps2_q[10] != tog_q);
    assign key_evt     = evt && !ps2_q[8] && map_hit && !clear;
    assign fresh_press = key_evt && ps2_q[9] && !km_q[map_key];
    assign key_release = key_evt && !ps2_q[9];

    // Until primed, take bit 10 straight from the input so stage 1 and the history agree
    assign tog_d = primed_q ? ps2_q[10] : ps2_key[10];

    always_comb begin
        km_d = km_q;
        if (clear) begin
            km_d = 16'h0000;
        end else if (key_evt) begin
            km_d[map_key] = ps2_q[9];
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_key_d = wait_key_q;
        unique case (state_q)
            ST_IDLE: begin
                if (wait_req) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!wait_req) begin
                    state_d = ST_IDLE;
                end else if (fresh_press) begin
                    wait_key_d = map_key;
                    state_d    = WAIT_ON_RELEASE ? ST_HELD : ST_DONE;
                end
            end
            ST_HELD: begin
                if (!wait_req) begin
                    state_d = ST_IDLE;
                end else if (key_release && (map_key == wait_key_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_ACK;
            ST_ACK: begin
                if (!wait_req) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear) state_d = ST_IDLE;
    end

    assign done_d = (state_q == ST_DONE);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            ps2_q      <= 11'd0;
            tog_q      <= 1'b0;
            primed_q   <= 1'b0;
            km_q       <= 16'h0000;
            state_q    <= ST_IDLE;
            wait_key_q <= 4'h0;
            done_q     <= 1'b0;
        end else begin
            ps2_q      <= ps2_key;
            tog_q      <= tog_d;
            primed_q   <= 1'b1;
            km_q       <= km_d;
            state_q    <= state_d;
            wait_key_q <= wait_key_d;
            done_q     <= done_d;
        end
    end

    assign key_matrix = km_q;
    assign wait_done  = done_q;
    assign wait_key   = wait_key_q;

endmodule
